// File: rtl/compare_sweep_pkg.sv
// Shared constants for the comparator self-test sweep: state codes, flag-vector
// bit positions and default sizing.
package compare_sweep_pkg;

  localparam int W_DEFAULT       = 4;
  localparam int TIMEOUT_DEFAULT = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Flag vector layout is {lt, gt, eq}.
  localparam int FLAG_W = 3;
  localparam int LT_BIT = 2;
  localparam int GT_BIT = 1;
  localparam int EQ_BIT = 0;

endpackage

// File: rtl/compare_golden.sv
// Reference comparator: one-hot {lt, gt, eq} of two W-bit operands, either
// unsigned or two's complement depending on is_signed.
module compare_golden
  import compare_sweep_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic              is_signed,
  output logic [FLAG_W-1:0] flags
);

  // One extra bit lets both modes share a single signed comparison.
  logic signed [W:0] xs;
  logic signed [W:0] ys;

  always_comb begin
    xs            = is_signed ? $signed({x[W-1], x}) : $signed({1'b0, x});
    ys            = is_signed ? $signed({y[W-1], y}) : $signed({1'b0, y});
    flags         = '0;
    flags[LT_BIT] = (xs < ys);
    flags[GT_BIT] = (xs > ys);
    flags[EQ_BIT] = (xs == ys);
  end

endmodule

// File: rtl/compare_sweep.sv
// Comparator self-test initiator: sweeps every (x,y) pair, checks each response
// against compare_golden. Optional COMPARE_SWEEP_STOP_ON_ERR_EN halts on first mismatch.
module compare_sweep
  import compare_sweep_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           MAX10_CLK1_50,
  input  logic           RESET_N,
  input  logic           start,
  input  logic           mode_signed,
  output logic           req,
  output logic [W-1:0]   op_x,
  output logic [W-1:0]   op_y,
  output logic           op_signed,
  input  logic           rsp_valid,
  input  logic           rsp_lt,
  input  logic           rsp_gt,
  input  logic           rsp_eq,
  output logic           busy,
  output logic           done,
  output logic           fail,
  output logic           timeout_seen,
  output logic [2*W:0]   pair_cnt,
  output logic [2*W:0]   err_cnt,
  output logic [2*W-1:0] first_fail
);

  localparam int PW = 2 * W;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [PW-1:0]     pair_idx;
  logic [CW-1:0]     wait_cnt;
  logic [FLAG_W-1:0] rsp_flags;
  logic              to_flag;
  logic [FLAG_W-1:0] golden;
  logic              mismatch;
  logic              stop_now;
  logic              last_pair;

  function automatic logic [PW:0] sat_inc(input logic [PW:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  compare_golden #(.W(W)) u_golden (
    .x        (op_x),
    .y        (op_y),
    .is_signed(op_signed),
    .flags    (golden)
  );

  assign op_x      = pair_idx[PW-1:W];
  assign op_y      = pair_idx[W-1:0];
  assign req       = (state == ST_REQ);
  assign busy      = (state == ST_REQ) || (state == ST_CHECK);
  assign done      = (state == ST_DONE);
  assign fail      = |err_cnt;
  assign last_pair = &pair_idx;
  // Golden is always one-hot, so any multi-hot or empty response also mismatches.
  assign mismatch  = to_flag || (rsp_flags != golden);

`ifdef COMPARE_SWEEP_STOP_ON_ERR_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // Captured response flags are pure data and are always written before use.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (state == ST_REQ) begin
      if (rsp_valid) begin
        rsp_flags[LT_BIT] <= rsp_lt;
        rsp_flags[GT_BIT] <= rsp_gt;
        rsp_flags[EQ_BIT] <= rsp_eq;
      end else begin
        rsp_flags <= '0;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) begin
      state        <= ST_IDLE;
      pair_idx     <= '0;
      wait_cnt     <= '0;
      to_flag      <= 1'b0;
      op_signed    <= 1'b0;
      pair_cnt     <= '0;
      err_cnt      <= '0;
      first_fail   <= '0;
      timeout_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_REQ;
            pair_idx     <= '0;
            wait_cnt     <= '0;
            to_flag      <= 1'b0;
            op_signed    <= mode_signed;
            pair_cnt     <= '0;
            err_cnt      <= '0;
            first_fail   <= '0;
            timeout_seen <= 1'b0;
          end
        end
        ST_REQ: begin
          // A response arriving on the last allowed cycle still counts.
          if (rsp_valid) begin
            to_flag <= 1'b0;
            state   <= ST_CHECK;
          end else if (wait_cnt == WAIT_LAST) begin
            to_flag <= 1'b1;
            state   <= ST_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          pair_cnt <= pair_cnt + 1'b1;
          if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (err_cnt == '0) first_fail <= pair_idx;
            if (to_flag) timeout_seen <= 1'b1;
          end
          if (last_pair || stop_now) begin
            state <= ST_DONE;
          end else begin
            pair_idx <= pair_idx + 1'b1;
            wait_cnt <= '0;
            state    <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
